// File: rtl/crypto_seq_ctrl_pkg.sv
// Shared types and default sizes for the crypto operation sequencer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package crypto_seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        ARM,
        RUN,
        GAP
    } seq_state_t;

    localparam int DATA_WIDTH_DEF = 128;
    localparam int KEY_WIDTH_DEF  = 128;
    localparam int CNT_WIDTH_DEF  = 16;
    localparam int GAP_WIDTH_DEF  = 8;
    localparam int TIMEOUT_DEF    = 1024;

    // Width of the shared gap/timeout down-counter is the larger of the two needs.
    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/crypto_seq_ctrl_if.sv
// Sequencer-to-crypto-core bus: load strobe, key, text out; result and busy back.
// Latency: wires only, no storage.
// Backpressure: core signals busy after load; the sequencer waits on it.
interface crypto_seq_ctrl_if
    import crypto_seq_pkg::*;
#(
    parameter int pDATA_WIDTH = DATA_WIDTH_DEF,
    parameter int pKEY_WIDTH  = KEY_WIDTH_DEF
);
    logic                   core_load_o;
    logic [pKEY_WIDTH-1:0]  core_key_o;
    logic [pDATA_WIDTH-1:0] core_data_o;
    logic [pDATA_WIDTH-1:0] core_data_i;
    logic                   core_busy_i;

    modport master (
        output core_load_o,
        output core_key_o,
        output core_data_o,
        input  core_data_i,
        input  core_busy_i
    );

    modport slave (
        input  core_load_o,
        input  core_key_o,
        input  core_data_o,
        output core_data_i,
        output core_busy_i
    );
endinterface

// File: rtl/crypto_seq_ctrl.sv
// Runs N back-to-back core operations per start, optional chaining, idle gaps, scope trigger, timeout abort.
// Latency: load one cycle after start; result/done one cycle after the core drops busy.
// Backpressure: waits on core busy; start is ignored unless idle and not in the done cycle.
module crypto_seq_ctrl
    import crypto_seq_pkg::*;
#(
    parameter int pDATA_WIDTH = DATA_WIDTH_DEF,
    parameter int pKEY_WIDTH  = KEY_WIDTH_DEF,
    parameter int pCNT_WIDTH  = CNT_WIDTH_DEF,
    parameter int pGAP_WIDTH  = GAP_WIDTH_DEF,
    parameter int pTIMEOUT    = TIMEOUT_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start_i,
    input  logic [pCNT_WIDTH-1:0]  count_i,
    input  logic [pGAP_WIDTH-1:0]  gap_i,
    input  logic                   chain_i,
    input  logic                   trig_all_i,
    input  logic [pKEY_WIDTH-1:0]  key_i,
    input  logic [pDATA_WIDTH-1:0] text_i,
    crypto_seq_ctrl_if.master      core,
    output logic                   busy_o,
    output logic                   done_o,
    output logic                   err_o,
    output logic [pDATA_WIDTH-1:0] result_o,
    output logic [pCNT_WIDTH-1:0]  op_cnt_o,
    output logic                   trigger_o
);
    localparam int TW = $clog2(pTIMEOUT);
    localparam int CW = max_int(TW, pGAP_WIDTH);
    localparam logic [CW-1:0] TMO_LOAD = CW'(pTIMEOUT - 1);

    seq_state_t             state_q;
    seq_state_t             state_d;
    logic [pCNT_WIDTH-1:0]  count_q;
    logic [pCNT_WIDTH-1:0]  op_cnt_q;
    logic [pGAP_WIDTH-1:0]  gap_q;
    logic                   chain_q;
    logic                   trig_all_q;
    logic [pKEY_WIDTH-1:0]  key_q;
    logic [pDATA_WIDTH-1:0] text_q;
    logic [pDATA_WIDTH-1:0] result_q;
    logic [CW-1:0]          cnt_q;
    logic                   done_q;
    logic                   err_q;

    logic                   accept;
    logic                   capture;
    logic                   timeout;
    logic                   last_op;

    // This capture completes the run when it brings the op count up to the latched count.
    assign last_op = ((op_cnt_q + pCNT_WIDTH'(1)) == count_q);

    // Next-state and per-cycle control decode.
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        capture = 1'b0;
        timeout = 1'b0;
        case (state_q)
            IDLE: begin
                // The done cycle is treated as still part of the old run.
                if (start_i && !done_q) begin
                    accept = 1'b1;
                    if (count_i != '0) begin
                        state_d = LOAD;
                    end
                end
            end
            LOAD: state_d = ARM;
            ARM:  state_d = RUN;
            RUN: begin
                if (!core.core_busy_i) begin
                    capture = 1'b1;
                    if (last_op) begin
                        state_d = IDLE;
                    end else if (gap_q == '0) begin
                        state_d = LOAD;
                    end else begin
                        state_d = GAP;
                    end
                end else if (cnt_q == '0) begin
                    timeout = 1'b1;
                    state_d = IDLE;
                end
            end
            GAP: begin
                if (cnt_q == '0) begin
                    state_d = LOAD;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Run parameters, shared gap/timeout counter, result capture and status flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q    <= '0;
            op_cnt_q   <= '0;
            gap_q      <= '0;
            chain_q    <= 1'b0;
            trig_all_q <= 1'b0;
            key_q      <= '0;
            text_q     <= '0;
            result_q   <= '0;
            cnt_q      <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (accept) begin
                count_q    <= count_i;
                gap_q      <= gap_i;
                chain_q    <= chain_i;
                trig_all_q <= trig_all_i;
                key_q      <= key_i;
                text_q     <= text_i;
                op_cnt_q   <= '0;
                err_q      <= 1'b0;
                if (count_i == '0) begin
                    done_q <= 1'b1;
                end
            end
            // ARM arms the timeout; a capture reloads for the gap; RUN/GAP count down.
            if (state_q == ARM) begin
                cnt_q <= TMO_LOAD;
            end else if (capture) begin
                cnt_q <= CW'(gap_q) - CW'(1);
            end else if (state_q == RUN || state_q == GAP) begin
                cnt_q <= cnt_q - CW'(1);
            end
            if (capture) begin
                result_q <= core.core_data_i;
                op_cnt_q <= op_cnt_q + pCNT_WIDTH'(1);
                done_q   <= last_op;
            end
            if (timeout) begin
                err_q  <= 1'b1;
                done_q <= 1'b1;
            end
        end
    end

    assign busy_o    = (state_q != IDLE);
    assign done_o    = done_q;
    assign err_o     = err_q;
    assign result_o  = result_q;
    assign op_cnt_o  = op_cnt_q;
    assign trigger_o = (state_q inside {LOAD, ARM, RUN}) && (trig_all_q || (op_cnt_q == '0));

    assign core.core_load_o = (state_q == LOAD);
    assign core.core_key_o  = key_q;
    // Text is only driven during the load strobe; chained ops after the first reuse the last result.
    assign core.core_data_o = (state_q != LOAD)                  ? '0       :
                              (chain_q && (op_cnt_q != '0))      ? result_q : text_q;

endmodule

// File: tb/tb_crypto_seq_ctrl.sv
// Directed bench for crypto_seq_ctrl with a mock core (busy for 10 cycles, result = data ^ key).
// Latency: n/a.
// Backpressure: n/a.
module tb_crypto_seq_ctrl;

    localparam int L = 10;

    typedef struct {
        int           cyc;
        logic [127:0] dat;
    } load_t;

    typedef struct {
        int           cyc;
        logic [127:0] res;
        logic [15:0]  opc;
        logic         err;
    } done_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         start_i;
    logic [15:0]  count_i;
    logic [7:0]   gap_i;
    logic         chain_i;
    logic         trig_all_i;
    logic [127:0] key_i;
    logic [127:0] text_i;
    logic         busy_o;
    logic         done_o;
    logic         err_o;
    logic [127:0] result_o;
    logic [15:0]  op_cnt_o;
    logic         trigger_o;

    crypto_seq_ctrl_if #(.pDATA_WIDTH(128), .pKEY_WIDTH(128)) cif ();

    crypto_seq_ctrl #(
        .pDATA_WIDTH (128),
        .pKEY_WIDTH  (128),
        .pCNT_WIDTH  (16),
        .pGAP_WIDTH  (8),
        .pTIMEOUT    (16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start_i    (start_i),
        .count_i    (count_i),
        .gap_i      (gap_i),
        .chain_i    (chain_i),
        .trig_all_i (trig_all_i),
        .key_i      (key_i),
        .text_i     (text_i),
        .core       (cif),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .err_o      (err_o),
        .result_o   (result_o),
        .op_cnt_o   (op_cnt_o),
        .trigger_o  (trigger_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Mock core: busy for L cycles starting the cycle after load, or forever when stuck.
    logic stuck = 1'b0;
    int   rem;
    always @(posedge clk) begin
        if (rst) begin
            cif.core_busy_i <= 1'b0;
            cif.core_data_i <= '0;
            rem             <= 0;
        end else if (cif.core_load_o) begin
            cif.core_busy_i <= 1'b1;
            cif.core_data_i <= cif.core_data_o ^ cif.core_key_o;
            rem             <= L - 1;
        end else if (cif.core_busy_i) begin
            if (!stuck && rem == 0) cif.core_busy_i <= 1'b0;
            else if (rem != 0)      rem <= rem - 1;
        end
    end

    int    passed = 0;
    int    total  = 0;
    int    base   = 0;
    int    rel    = 0;
    int    extra_evt = 0;
    int    trig_mode = 0;
    logic  done_seen = 1'b0;
    load_t exp_load[$];
    done_t exp_done[$];

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] want);
        total++;
        assert (obs === want) passed++;
        else begin
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
        end
    endtask

    // Advance to the next falling edge and score whatever the DUT produced in this cycle.
    task automatic tick();
        load_t ld;
        done_t dn;
        @(negedge clk);
        rel = cyc - base;
        if (cif.core_load_o) begin
            if (exp_load.size() == 0) extra_evt++;
            else begin
                ld = exp_load.pop_front();
                check("load_cycle", rel, ld.cyc);
                check("load_data", cif.core_data_o, ld.dat);
            end
        end
        if (done_o) begin
            done_seen = 1'b1;
            if (exp_done.size() == 0) extra_evt++;
            else begin
                dn = exp_done.pop_front();
                check("done_cycle", rel, dn.cyc);
                check("done_result", result_o, dn.res);
                check("done_op_cnt", op_cnt_o, dn.opc);
                check("done_err", err_o, dn.err);
            end
        end
        if (trig_mode == 1)
            check("trigger_all", trigger_o, (rel >= 1 && rel <= 40 && ((rel - 1) % 14) <= 11));
        else if (trig_mode == 2)
            check("trigger_first", trigger_o, (rel >= 1 && rel <= 12));
    endtask

    task automatic push_load(input int c, input logic [127:0] d);
        load_t e;
        e.cyc = c; e.dat = d;
        exp_load.push_back(e);
    endtask

    task automatic push_done(input int c, input logic [127:0] r, input logic [15:0] n, input logic e);
        done_t d;
        d.cyc = c; d.res = r; d.opc = n; d.err = e;
        exp_done.push_back(d);
    endtask

    // Drive a start pulse at a falling edge; returns after observing cycle 1.
    task automatic launch(input logic [15:0] cnt, input logic [7:0] gap, input logic chain,
                          input logic tall, input logic [127:0] key, input logic [127:0] txt);
        count_i = cnt; gap_i = gap; chain_i = chain; trig_all_i = tall;
        key_i = key; text_i = txt;
        start_i = 1'b1;
        base = cyc;
        done_seen = 1'b0;
        tick();
        start_i = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (!done_seen && n < budget) begin
            tick();
            n++;
        end
        check("done_within_budget", done_seen, 1'b1);
    endtask

    task automatic drain_check(input string tag);
        check({tag, "_loads_left"}, exp_load.size(), 0);
        check({tag, "_dones_left"}, exp_done.size(), 0);
        check({tag, "_unexpected_events"}, extra_evt, 0);
    endtask

    localparam logic [127:0] K  = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    localparam logic [127:0] T  = 128'hDEAD_BEEF_CAFE_F00D_0BAD_C0DE_1234_5678;
    localparam logic [127:0] K2 = 128'h5A5A_A5A5_3C3C_C3C3_0F0F_F0F0_9696_6969;

    initial begin
        rst = 1'b1; start_i = 1'b0; count_i = '0; gap_i = '0; chain_i = 1'b0;
        trig_all_i = 1'b0; key_i = '0; text_i = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        tick();

        // Reset state
        check("rst_busy", busy_o, 1'b0);
        check("rst_done", done_o, 1'b0);
        check("rst_err", err_o, 1'b0);
        check("rst_result", result_o, 128'h0);
        check("rst_op_cnt", op_cnt_o, 16'h0);
        check("rst_trigger", trigger_o, 1'b0);
        check("rst_load", cif.core_load_o, 1'b0);
        check("rst_key", cif.core_key_o, 128'h0);
        check("rst_data", cif.core_data_o, 128'h0);

        // Single op: all-ones key over zero text
        push_load(1, 128'h0);
        push_done(13, {128{1'b1}}, 16'd1, 1'b0);
        launch(16'd1, 8'd0, 1'b0, 1'b0, {128{1'b1}}, 128'h0);
        check("t1_busy_running", busy_o, 1'b1);
        wait_done(60);
        tick();
        check("t1_busy_after", busy_o, 1'b0);
        drain_check("t1");

        // Three chained ops with a 2-cycle gap, trigger on every op
        push_load(1, T);
        push_load(15, T ^ K);
        push_load(29, T);
        push_done(41, T ^ K, 16'd3, 1'b0);
        trig_mode = 1;
        launch(16'd3, 8'd2, 1'b1, 1'b1, K, T);
        wait_done(80);
        trig_mode = 0;
        tick();
        drain_check("t2");

        // Three unchained ops, trigger on first op only
        push_load(1, T);
        push_load(15, T);
        push_load(29, T);
        push_done(41, T ^ K, 16'd3, 1'b0);
        trig_mode = 2;
        launch(16'd3, 8'd2, 1'b0, 1'b0, K, T);
        wait_done(80);
        trig_mode = 0;
        tick();
        drain_check("t3");

        // Core timeout: result keeps the previous run's value, op count stays 0
        stuck = 1'b1;
        push_load(1, T);
        push_done(19, T ^ K, 16'd0, 1'b1);
        launch(16'd2, 8'd0, 1'b0, 1'b0, K, T);
        wait_done(60);
        stuck = 1'b0;
        tick();
        check("t4_err_sticky", err_o, 1'b1);
        check("t4_busy_after", busy_o, 1'b0);
        tick();
        drain_check("t4");

        // Next start clears the error flag
        push_load(1, 128'h0);
        push_done(13, K, 16'd1, 1'b0);
        launch(16'd1, 8'd0, 1'b0, 1'b0, K, 128'h0);
        check("t4b_err_cleared", err_o, 1'b0);
        check("t4b_op_cnt_cleared", op_cnt_o, 16'h0);
        wait_done(60);
        tick();
        drain_check("t4b");

        // count=0: immediate done, no load; a start in the done cycle is ignored
        push_done(1, K, 16'd0, 1'b0);
        launch(16'd0, 8'd0, 1'b0, 1'b0, K2, T);
        wait_done(5);
        start_i = 1'b1; count_i = 16'd1;
        tick();
        start_i = 1'b0;
        check("t5_busy_low", busy_o, 1'b0);
        repeat (4) tick();
        check("t5_still_idle", busy_o, 1'b0);
        drain_check("t5");

        // Start re-pulsed mid-run is ignored
        push_load(1, T);
        push_done(13, T ^ K2, 16'd1, 1'b0);
        launch(16'd1, 8'd0, 1'b0, 1'b0, K2, T);
        tick();
        tick();
        start_i = 1'b1; count_i = 16'd2; text_i = K;
        tick();
        start_i = 1'b0;
        wait_done(60);
        tick();
        drain_check("t5b");

        // Reset in cycle 6 of a two-op run
        push_load(1, T);
        launch(16'd2, 8'd0, 1'b0, 1'b1, K, T);
        while (rel < 6) tick();
        rst = 1'b1;
        tick();
        check("t6_busy", busy_o, 1'b0);
        check("t6_done", done_o, 1'b0);
        check("t6_err", err_o, 1'b0);
        check("t6_result", result_o, 128'h0);
        check("t6_op_cnt", op_cnt_o, 16'h0);
        check("t6_trigger", trigger_o, 1'b0);
        check("t6_load", cif.core_load_o, 1'b0);
        check("t6_key", cif.core_key_o, 128'h0);
        check("t6_data", cif.core_data_o, 128'h0);
        rst = 1'b0;
        repeat (15) tick();
        check("t6_no_done", done_seen, 1'b0);
        drain_check("t6");

        // Fresh run after reset completes normally
        push_load(1, T);
        push_done(13, T ^ K, 16'd1, 1'b0);
        launch(16'd1, 8'd0, 1'b0, 1'b0, K, T);
        wait_done(60);
        tick();
        drain_check("t6b");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
